// File: rtl/imm_pkg.sv
// Shared RISC-V decode constants: immediate format codes, major opcodes and funct3 values.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_CSRI  = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADDI      = 3'd0;
    localparam logic [2:0] F3_SLLI      = 3'd1;
    localparam logic [2:0] F3_SLTI      = 3'd2;
    localparam logic [2:0] F3_SLTIU     = 3'd3;
    localparam logic [2:0] F3_XORI      = 3'd4;
    localparam logic [2:0] F3_SRLI_SRAI = 3'd5;
    localparam logic [2:0] F3_ORI       = 3'd6;
    localparam logic [2:0] F3_ANDI      = 3'd7;

    // Per-entry decode sideband stored alongside the immediate
    typedef struct packed {
        fmt_e fmt;
        logic illegal;
    } meta_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction for one 32-bit instruction word.
module imm_extract
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm_c,
    output fmt_e            fmt_c,
    output logic            illegal_c
);

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    always_comb begin
        imm_c     = '0;
        fmt_c     = FMT_NONE;
        illegal_c = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                fmt_c = FMT_I;
                imm_c = XLEN'($signed(instr[31:20]));
            end
            OPC_OP_IMM: begin
                if (funct3 == F3_SLLI || funct3 == F3_SRLI_SRAI) begin
                    fmt_c = FMT_SHAMT;
                    if (XLEN == 32) begin
                        // shamt[5] has no meaning on RV32
                        if (instr[25]) illegal_c = 1'b1;
                        else           imm_c     = XLEN'(instr[24:20]);
                    end else begin
                        imm_c = XLEN'(instr[25:20]);
                    end
                end else begin
                    // SLTIU included: its immediate is sign-extended too
                    fmt_c = FMT_I;
                    imm_c = XLEN'($signed(instr[31:20]));
                end
            end
            OPC_STORE: begin
                fmt_c = FMT_S;
                imm_c = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OPC_BRANCH: begin
                fmt_c = FMT_B;
                imm_c = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_c = FMT_U;
                imm_c = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OPC_JAL: begin
                fmt_c = FMT_J;
                imm_c = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            end
            OPC_SYSTEM: begin
                if (funct3[2]) begin
                    fmt_c = FMT_CSRI;
                    imm_c = XLEN'(instr[19:15]);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a DEPTH-entry circular output buffer and valid/ready handshakes.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      decode_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  ext_imm_c;
    fmt_e             ext_fmt_c;
    logic             ext_illegal_c;

    logic [XLEN-1:0]  mem_imm  [DEPTH];
    meta_t            mem_meta [DEPTH];
    logic [TAG_W-1:0] mem_tag  [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic             push_c, pop_c, load_new_c, load_mem_c;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr     (in_instr),
        .imm_c     (ext_imm_c),
        .fmt_c     (ext_fmt_c),
        .illegal_c (ext_illegal_c)
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push_c = in_valid & in_ready & ~flush;
    assign pop_c  = out_valid & out_ready;

    // Next occupancy/pointers and selection of the next presented head entry
    always_comb begin
        count_nx   = count;
        wr_ptr_nx  = wr_ptr;
        rd_ptr_nx  = rd_ptr;
        load_new_c = 1'b0;
        load_mem_c = 1'b0;
        if (flush) begin
            count_nx  = '0;
            wr_ptr_nx = '0;
            rd_ptr_nx = '0;
        end else begin
            if (push_c) wr_ptr_nx = ptr_inc(wr_ptr);
            if (pop_c)  rd_ptr_nx = ptr_inc(rd_ptr);
            count_nx = count + CNT_W'(push_c) - CNT_W'(pop_c);
            if (push_c && (count == '0 || (count == CNT_W'(1) && pop_c)))
                load_new_c = 1'b1;
            else if (pop_c && count > CNT_W'(1))
                load_mem_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_imm     <= '0;
            out_fmt     <= '0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
            decode_cnt  <= '0;
        end else begin
            count      <= count_nx;
            wr_ptr     <= wr_ptr_nx;
            rd_ptr     <= rd_ptr_nx;
            in_ready   <= (count_nx < CNT_W'(DEPTH));
            out_valid  <= (count_nx != '0);
            decode_cnt <= decode_cnt + 32'(pop_c);
            if (load_new_c) begin
                out_imm     <= ext_imm_c;
                out_fmt     <= 3'(ext_fmt_c);
                out_illegal <= ext_illegal_c;
                out_tag     <= in_tag;
            end else if (load_mem_c) begin
                out_imm     <= mem_imm[rd_ptr_nx];
                out_fmt     <= 3'(mem_meta[rd_ptr_nx].fmt);
                out_illegal <= mem_meta[rd_ptr_nx].illegal;
                out_tag     <= mem_tag[rd_ptr_nx];
            end
        end
    end

    // Storage array; contents are only meaningful under the occupancy counter
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_imm[wr_ptr]  <= ext_imm_c;
            mem_meta[wr_ptr] <= '{fmt: ext_fmt_c, illegal: ext_illegal_c};
            mem_tag[wr_ptr]  <= in_tag;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe; a 64-bit instance shares the 32-bit stimulus.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_tag;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm, out_tag, decode_cnt;
    logic [2:0]  out_fmt;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64, decode_cnt64;
    logic [2:0]  out_fmt64;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_illegal(out_illegal), .out_tag(out_tag), .decode_cnt(decode_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
        .out_illegal(out_illegal64), .out_tag(out_tag64), .decode_cnt(decode_cnt64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_tag = '0;
        tick(); tick();
        rst = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", in_ready); end
        checks++; if (decode_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", decode_cnt); end
        checks++; if (out_imm !== 32'd0) begin errors++; $display("FAIL reset_imm got %h exp 0", out_imm); end
        checks++; if (out_fmt !== 3'd0 || out_illegal !== 1'b0 || out_tag !== 32'd0) begin
            errors++; $display("FAIL reset_side got fmt %0d ill %0b tag %h exp 0", out_fmt, out_illegal, out_tag); end
        exp_cnt = 0;
    endtask

    task automatic test_formats();
        logic [31:0] vi  [12] = '{32'hFFF00093, 32'hFE000EE3, 32'hFE112C23, 32'h123452B7,
                                  32'hFFDFF06F, 32'hFFF03093, 32'h3002D073, 32'h00000073,
                                  32'h003100B3, 32'h02009093, 32'h4030D093, 32'h800000B7};
        logic [31:0] e32 [12] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                                  32'hFFFFFFFC, 32'hFFFFFFFF, 32'h5, 32'h0,
                                  32'h0, 32'h0, 32'h3, 32'h80000000};
        logic [63:0] e64 [12] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                                  64'h12345000, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFF,
                                  64'h5, 64'h0, 64'h0, 64'h20, 64'h3, 64'hFFFFFFFF80000000};
        logic [2:0]  ef  [12] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd5, 3'd1, 3'd7, 3'd0, 3'd0, 3'd6, 3'd6, 3'd4};
        logic        ei32[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 12; i++) begin
            in_instr = vi[i]; in_tag = 32'h100 + 32'(i * 4); in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fmt%0d_valid got %0b exp 1", i, out_valid); end
            checks++; if (out_imm !== e32[i]) begin errors++; $display("FAIL fmt%0d_imm32 got %h exp %h", i, out_imm, e32[i]); end
            checks++; if (out_imm64 !== e64[i]) begin errors++; $display("FAIL fmt%0d_imm64 got %h exp %h", i, out_imm64, e64[i]); end
            checks++; if (out_fmt !== ef[i] || out_fmt64 !== ef[i]) begin
                errors++; $display("FAIL fmt%0d_fmt got %0d/%0d exp %0d", i, out_fmt, out_fmt64, ef[i]); end
            checks++; if (out_illegal !== ei32[i] || out_illegal64 !== 1'b0) begin
                errors++; $display("FAIL fmt%0d_illegal got %0b/%0b exp %0b/0", i, out_illegal, out_illegal64, ei32[i]); end
            checks++; if (out_tag !== 32'h100 + 32'(i * 4)) begin
                errors++; $display("FAIL fmt%0d_tag got %h exp %h", i, out_tag, 32'h100 + 32'(i * 4)); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            exp_cnt++;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fmt%0d_drain got %0b exp 0", i, out_valid); end
        end
        checks++; if (decode_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL fmt_cnt got %0d exp %0d", decode_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        rst = 1'b0; tick(); rst = 1'b1; exp_cnt = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'hFFF00093; in_tag = 32'hA0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %0b exp 1", in_ready); end
        in_instr = 32'h123452B7; in_tag = 32'hB0;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %0b exp 0", in_ready); end
        in_instr = 32'hFE000EE3; in_tag = 32'hC0;
        tick();
        checks++; if (in_ready !== 1'b0 || out_tag !== 32'hA0 || out_imm !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL b2b_hold got rdy %0b tag %h imm %h exp 0 a0 ffffffff", in_ready, out_tag, out_imm); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_tag !== 32'hB0 || out_imm !== 32'h12345000 || in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_second got tag %h imm %h rdy %0b exp b0 12345000 1", out_tag, out_imm, in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_tag !== 32'hC0 || out_imm !== 32'hFFFFFFFC) begin
            errors++; $display("FAIL b2b_third got v %0b tag %h imm %h exp 1 c0 fffffffc", out_valid, out_tag, out_imm); end
        tick();
        out_ready = 1'b0;
        exp_cnt = 3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b exp 0", out_valid); end
        checks++; if (decode_cnt !== 32'd3) begin errors++; $display("FAIL b2b_cnt got %0d exp 3", decode_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'hFFF00093; in_tag = 32'h1; tick();
        in_instr = 32'hFE112C23; in_tag = 32'h2; tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full got %0b exp 0", in_ready); end
        in_instr = 32'h123452B7; in_tag = 32'h3; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state got v %0b rdy %0b exp 0 1", out_valid, in_ready); end
        checks++; if (decode_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL flush_cnt got %0d exp %0d", decode_cnt, exp_cnt); end
        // one buffered entry, then flush while an acceptable instruction is offered
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'h4; tick();
        in_instr = 32'h123452B7; in_tag = 32'h5; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %0b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_after got v %0b rdy %0b exp 0 1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'hFE000EE3; in_tag = 32'h7; tick();
        in_instr = 32'h3002D073; in_tag = 32'h8; tick();
        in_valid = 1'b0; out_ready = 1'b1; rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_state got v %0b rdy %0b exp 0 1", out_valid, in_ready); end
        checks++; if (out_imm !== 32'd0 || out_tag !== 32'd0 || decode_cnt !== 32'd0) begin
            errors++; $display("FAIL rstmid_regs got imm %h tag %h cnt %0d exp 0 0 0", out_imm, out_tag, decode_cnt); end
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || decode_cnt !== 32'd0) begin
            errors++; $display("FAIL rstmid_after got v %0b cnt %0d exp 0 0", out_valid, decode_cnt); end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 2, output buffer entries; legal range 2..8.
REQ-003 Parameter TAG_W, default 32, width of the sideband tag (PC) carried with each instruction.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-low.
REQ-006 flush  in  1  discards all buffered results.
REQ-007 in_valid  in  1  instruction offered.
REQ-008 in_ready  out  1  block accepts the offered instruction.
REQ-009 in_instr  in  32  raw instruction word.
REQ-010 in_tag  in  TAG_W  sideband value, passed through unmodified.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 out_imm  out  XLEN  immediate value.
REQ-014 out_fmt  out  3  format code: NONE, I, S, B, U, J, SHAMT, CSRI.
REQ-015 out_illegal  out  1  encoding invalid for the selected XLEN.
REQ-016 out_tag  out  TAG_W  tag of the presented result.
REQ-017 decode_cnt  out  32  count of results consumed since reset; wraps modulo 2^32.

Function
REQ-018 The block SHALL accept an instruction on each cycle in which in_valid and in_ready are both high.
REQ-019 in_ready SHALL be a registered signal, high exactly when buffer occupancy is below DEPTH; it has no combinational path from out_ready.
REQ-020 Latency SHALL be one cycle: an instruction accepted into an empty buffer is presented with out_valid high on the next cycle.
REQ-021 A result SHALL leave the buffer on each cycle in which out_valid and out_ready are both high.
REQ-022 Results SHALL be presented strictly in acceptance order; occupancy is unchanged when a push and a pop occur in the same cycle.
REQ-023 While out_valid is high and out_ready is low, all out_* signals SHALL hold stable.
REQ-024 Immediate extraction SHALL follow the formats below; every immediate is sign-extended from its top bit to XLEN unless stated otherwise.
  - I (LOAD, JALR, OP-IMM other than shifts): instr[31:20].
  - SLTIU is sign-extended, not zero-extended.
  - S: instr[31:25], instr[11:7].
  - B: instr[31], instr[7], instr[30:25], instr[11:8], 0.
  - U (LUI, AUIPC): instr[31:12] followed by 12 zeros.
  - J: instr[31], instr[19:12], instr[20], instr[30:21], 0.
REQ-025 SHAMT (SLLI, SRLI, SRAI) SHALL be zero-extended: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
REQ-026 When XLEN=32 and instr[25]=1 on a shift, the block SHALL assert out_illegal and output imm 0.
REQ-027 SYSTEM opcode with funct3[2]=1 SHALL output fmt CSRI with imm equal to zero-extended instr[19:15].
REQ-028 SYSTEM opcode with any other funct3 SHALL output fmt NONE and imm 0.
REQ-029 Any opcode not listed (including R-type) SHALL output fmt NONE, imm 0 and out_illegal 0; out_illegal is raised only by REQ-026.
REQ-030 Extraction logic SHALL be fully combinational with every output assigned on every path, so that no latches are inferred.
REQ-031 On flush, occupancy SHALL be 0 on the next cycle, out_valid low and in_ready high.
REQ-032 An input handshake in the flush cycle SHALL be dropped.
REQ-033 decode_cnt SHALL increment by one for each output handshake and SHALL be unaffected by flush.

Reset
REQ-034 While rst is low at a clock edge, the block SHALL set occupancy and read/write pointers to 0 and decode_cnt to 0.
REQ-035 After reset, out_valid SHALL be 0, in_ready SHALL be 1, and out_imm, out_fmt, out_illegal and out_tag SHALL be 0.
REQ-036 Reset asserted mid-transfer SHALL discard all buffered entries without emitting them.

Structure
REQ-037 Format codes, opcode constants and funct3 constants SHALL reside in shared package imm_pkg, reused by the decoder and ALU control.
REQ-038 Combinational extraction SHALL be a sub-module imm_extract, parameterised by XLEN.
REQ-039 The buffer SHALL be a circular array of DEPTH entries with an explicit occupancy counter.

Verification
REQ-040 Reset: hold rst low 2 cycles -> out_valid=0, in_ready=1, decode_cnt=0, out_imm=0.
REQ-041 Send 0xFFF00093 (addi x1,x0,-1) with tag 0x100 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=I, tag=0x100.
REQ-042 Send 0xFE000EE3 (beq -4) -> imm=0xFFFFFFFC, fmt=B; with XLEN=64 -> imm=0xFFFFFFFFFFFFFFFC.
REQ-043 DEPTH=2, hold out_ready=0, offer 3 instructions back-to-back -> two accepted, then in_ready=0 with the third held; raise out_ready -> all three emitted in order, decode_cnt=3.
REQ-044 Fill 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, the offered instruction is lost, decode_cnt unchanged.
REQ-045 XLEN=32, send 0x02009093 (slli shamt 32) -> out_illegal=1, imm=0, fmt=SHAMT; with XLEN=64 -> out_illegal=0, imm=0x20.
